id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
Instruction-decode stage of the 5-stage pipeline. It sits directly downstream of the fetch stage and consumes its registered PC and instruction. It decodes opcode fields, reads the 32x32 register file (written by the write-back port), and selects the immediate. It also computes the branch target and holds the results in the ID/EX pipeline register. It exports source-register indices to the hazard unit and honours freeze (stall) and flush (bubble) requests.

Parameters:
- REG_COUNT, 32, number of architectural registers; R0 reads as zero.
- DATA_W, 32, datapath and register width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  hold the ID/EX register (load-use stall).
- flush  in  1  load a bubble (NOP) into the ID/EX register (taken branch).
- pc_in  in  32  PC from the fetch pipeline register (already PC+4).
- instr_in  in  32  instruction from the fetch pipeline register.
- wb_en  in  1  register-file write enable from write-back.
- wb_dest  in  5  write-back destination index.
- wb_val  in  32  write-back data.
- src1  out  5  instr_in[20:16], combinational, for the hazard unit.
- src2  out  5  instr_in[15:11], or instr_in[25:21] for ST; combinational.
- two_src  out  1  current instruction reads src2; combinational.
- pc_out  out  32  registered PC.
- val1  out  32  registered R[src1].
- val2  out  32  registered R[src2], or the sign-extended imm when is_imm.
- st_val  out  32  registered R[dest], the store data.
- dest  out  5  registered instr[25:21].
- exe_cmd  out  4  registered ALU command.
- mem_r_en, mem_w_en, wb_en_out  out  1 each  registered control bits.
- br_type  out  2  registered: 0 none, 1 BEZ, 2 BNE, 3 JMP.
- br_addr  out  32  registered pc_in + (sext(imm16) << 2).

Behaviour:
- Field layout: opcode[31:26], dest[25:21], src1[20:16], src2[15:11], imm[15:0].
- Opcode to exe_cmd / control mapping:
  - 0 NOP: all enables 0.
  - 1 ADD / 3 SUB / 5 AND / 6 OR / 7 NOR / 8 XOR / 9 SLA / 10 SLL / 11 SRA / 12 SRL: exe_cmd 1/2/3/4/5/6/7/7/8/9, wb_en 1.
  - 32 ADDI / 33 SUBI: exe_cmd 1/2, is_imm, wb_en 1.
  - 36 LD: ADD, is_imm, mem_r_en 1, wb_en 1.
  - 37 ST: ADD, is_imm, mem_w_en 1.
  - 40 BEZ: br_type 1. 41 BNE: br_type 2, two_src 1. 42 JMP: br_type 3.
  - Any other opcode decodes as NOP.
- two_src = 1 for R-type ALU ops, ST and BNE; 0 otherwise.
- Register file: REG_COUNT x DATA_W, written on rising clk when wb_en and wb_dest != 0. Writes to R0 are ignored, and R0 always reads 0.
- Read-during-write: when wb_en and wb_dest equals a read index (not 0) in the same cycle, the read returns wb_val (internal bypass).
- Sign extension: imm is sign-extended to 32 bits; all arithmetic is modulo 2^32.
- Latency: 1 cycle, from instr_in/pc_in to the registered outputs.
- ID/EX register priority, evaluated per rising edge:
  - rst: all outputs and control bits 0, and register file cleared to 0.
  - flush: control bits (mem_r_en, mem_w_en, wb_en_out, br_type, exe_cmd) set to 0; data fields don't-care, driven 0.
  - freeze: all registered outputs hold.
  - otherwise: load the decoded values.
- Flush has priority over freeze.
- The register-file write proceeds regardless of freeze and flush; only rst blocks it.
- Reset mid-operation: the next cycle presents a NOP; no partial state survives.
- src1, src2 and two_src are purely combinational from instr_in and are unaffected by freeze.

Decomposition:
- Shared package holds the opcode constants, exe_cmd encodings, br_type encodings and field bit positions.
- One natural sub-module: reg_file (2 read ports, 1 write port, bypass, R0 hardwired).
- The decoder and the pipeline register stay in id_stage.

Test Plan:
- rst held 2 cycles, then released with instr_in=0 → all registered outputs 0; R1..R31 read 0.
- Write R1=5 and R2=7 via WB; instr_in=0x04611000 (ADD R3,R1,R2), pc_in=8 → next cycle val1=5, val2=7, dest=3, exe_cmd=1, wb_en_out=1, pc_out=8.
- ADDI R4,R1,-4 (imm 0xFFFC) → val2=0xFFFFFFFC, is_imm path taken, wb_en_out=1.
- BNE, pc_in=0x20, imm=3 → br_type=2, br_addr=0x2C, two_src=1.
- WB writes R1=9 in the same cycle an ADD reads R1 → val1=9. A WB write to R0 leaves R0 reading 0.
- freeze=1 for 2 cycles with changing instr_in → outputs hold. flush=1 together with freeze=1 → control bits 0 on the next cycle.

Source files
------------

// File: rtl/id_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_stage_pkg
// Shared definitions for the instruction-decode stage: instruction field
// positions, opcode values, ALU command encodings, branch-type encodings and
// a helper that builds the word-scaled branch offset.
// No ports (package only).
// ---------------------------------------------------------------------------
package id_stage_pkg;

  // Instruction field positions
  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 26;
  localparam int DEST_HI = 25;
  localparam int DEST_LO = 21;
  localparam int SRC1_HI = 20;
  localparam int SRC1_LO = 16;
  localparam int SRC2_HI = 15;
  localparam int SRC2_LO = 11;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;

  // Opcode values. Anything not listed here decodes as a NOP.
  typedef enum logic [5:0] {
    OP_NOP  = 6'd0,
    OP_ADD  = 6'd1,
    OP_SUB  = 6'd3,
    OP_AND  = 6'd5,
    OP_OR   = 6'd6,
    OP_NOR  = 6'd7,
    OP_XOR  = 6'd8,
    OP_SLA  = 6'd9,
    OP_SLL  = 6'd10,
    OP_SRA  = 6'd11,
    OP_SRL  = 6'd12,
    OP_ADDI = 6'd32,
    OP_SUBI = 6'd33,
    OP_LD   = 6'd36,
    OP_ST   = 6'd37,
    OP_BEZ  = 6'd40,
    OP_BNE  = 6'd41,
    OP_JMP  = 6'd42
  } opcode_e;

  // ALU commands handed to the execute stage. SLA and SLL share EXE_SHL
  // because an arithmetic left shift is identical to a logical one.
  typedef enum logic [3:0] {
    EXE_NONE = 4'd0,
    EXE_ADD  = 4'd1,
    EXE_SUB  = 4'd2,
    EXE_AND  = 4'd3,
    EXE_OR   = 4'd4,
    EXE_NOR  = 4'd5,
    EXE_XOR  = 4'd6,
    EXE_SHL  = 4'd7,
    EXE_SRA  = 4'd8,
    EXE_SRL  = 4'd9
  } exe_cmd_e;

  // Branch kinds
  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_BEZ  = 2'd1,
    BR_BNE  = 2'd2,
    BR_JMP  = 2'd3
  } br_type_e;

  // Sign-extended 16-bit immediate scaled to a byte offset (word units << 2)
  function automatic logic [31:0] brOffset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// ---------------------------------------------------------------------------
// id_stage_reg_file
// REG_COUNT x DATA_W register file with two combinational read ports and one
// synchronous write port. R0 is hardwired to zero; a write and a read of the
// same non-zero index in the same cycle returns the write data (bypass).
// Ports:
//   clk, rst           clock, synchronous active-high reset (clears all regs)
//   i_we, i_waddr,     write enable / index / data
//   i_wdata
//   i_raddr1, i_raddr2 read indices
//   o_rdata1, o_rdata2 read data
// ---------------------------------------------------------------------------
module id_stage_reg_file #(
  parameter int REG_COUNT = 32,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);

  logic [DATA_W-1:0] r_regs [REG_COUNT];
  logic              w_wrValid;

  assign w_wrValid = i_we && (i_waddr != '0);

  // Storage: reset clears every entry, writes to index 0 are dropped so R0
  // stays zero even without the read-side forcing below.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wrValid) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read ports: R0 forced to zero, otherwise bypass a same-cycle write so the
  // decoder sees the value write-back is committing this edge.
  always_comb begin
    o_rdata1 = r_regs[i_raddr1];
    o_rdata2 = r_regs[i_raddr2];
    if (i_raddr1 == '0) begin
      o_rdata1 = '0;
    end else if (w_wrValid && (i_waddr == i_raddr1)) begin
      o_rdata1 = i_wdata;
    end
    if (i_raddr2 == '0) begin
      o_rdata2 = '0;
    end else if (w_wrValid && (i_waddr == i_raddr2)) begin
      o_rdata2 = i_wdata;
    end
  end

endmodule

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
// Instruction-decode stage: decodes the fetched instruction, reads the
// register file, selects the immediate, computes the branch target and holds
// everything in the ID/EX pipeline register (1-cycle latency).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   freeze, flush             hold / bubble the ID/EX register (flush wins)
//   pc_in, instr_in           PC (+4) and instruction from fetch
//   wb_en, wb_dest, wb_val    register-file write port from write-back
//   src1, src2, two_src       combinational source indices for hazard unit
//   pc_out, val1, val2,       registered datapath fields
//   st_val, dest, br_addr
//   exe_cmd, mem_r_en,        registered control fields
//   mem_w_en, wb_en_out,
//   br_type
// ---------------------------------------------------------------------------
module id_stage
  import id_stage_pkg::*;
#(
  parameter int REG_COUNT = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       instr_in,
  input  logic              wb_en,
  input  logic [4:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_val,
  output logic [4:0]        src1,
  output logic [4:0]        src2,
  output logic              two_src,
  output logic [31:0]       pc_out,
  output logic [DATA_W-1:0] val1,
  output logic [DATA_W-1:0] val2,
  output logic [DATA_W-1:0] st_val,
  output logic [4:0]        dest,
  output logic [3:0]        exe_cmd,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              wb_en_out,
  output logic [1:0]        br_type,
  output logic [31:0]       br_addr
);

  logic [5:0]        w_opcode;
  logic [4:0]        w_destIdx;
  logic [4:0]        w_src2Field;
  logic [15:0]       w_imm;
  logic [DATA_W-1:0] w_immExt;
  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rdata2;
  logic [31:0]       w_brAddr;

  exe_cmd_e          w_exeCmd;
  br_type_e          w_brType;
  logic              w_memR;
  logic              w_memW;
  logic              w_wbEn;
  logic              w_isImm;
  logic              w_isStore;
  logic              w_twoSrc;

  logic [31:0]       r_pc;
  logic [DATA_W-1:0] r_val1;
  logic [DATA_W-1:0] r_val2;
  logic [DATA_W-1:0] r_stVal;
  logic [4:0]        r_dest;
  exe_cmd_e          r_exeCmd;
  logic              r_memR;
  logic              r_memW;
  logic              r_wbEn;
  br_type_e          r_brType;
  logic [31:0]       r_brAddr;

  assign w_opcode    = instr_in[OPC_HI:OPC_LO];
  assign w_destIdx   = instr_in[DEST_HI:DEST_LO];
  assign w_src2Field = instr_in[SRC2_HI:SRC2_LO];
  assign w_imm       = instr_in[IMM_HI:IMM_LO];
  assign w_immExt    = {{(DATA_W-16){w_imm[15]}}, w_imm};
  assign w_brAddr    = pc_in + brOffset(w_imm);

  // Opcode decoder: every control output gets a NOP default first, so any
  // opcode without a case item falls through as a bubble.
  always_comb begin
    w_exeCmd  = EXE_NONE;
    w_brType  = BR_NONE;
    w_memR    = 1'b0;
    w_memW    = 1'b0;
    w_wbEn    = 1'b0;
    w_isImm   = 1'b0;
    w_isStore = 1'b0;
    w_twoSrc  = 1'b0;
    case (w_opcode)
      OP_ADD:  begin w_exeCmd = EXE_ADD; w_wbEn = 1'b1; w_twoSrc = 1'b1; end
      OP_SUB:  begin w_exeCmd = EXE_SUB; w_wbEn = 1'b1; w_twoSrc = 1'b1; end
      OP_AND:  begin w_exeCmd = EXE_AND; w_wbEn = 1'b1; w_twoSrc = 1'b1; end
      OP_OR:   begin w_exeCmd = EXE_OR;  w_wbEn = 1'b1; w_twoSrc = 1'b1; end
      OP_NOR:  begin w_exeCmd = EXE_NOR; w_wbEn = 1'b1; w_twoSrc = 1'b1; end
      OP_XOR:  begin w_exeCmd = EXE_XOR; w_wbEn = 1'b1; w_twoSrc = 1'b1; end
      OP_SLA:  begin w_exeCmd = EXE_SHL; w_wbEn = 1'b1; w_twoSrc = 1'b1; end
      OP_SLL:  begin w_exeCmd = EXE_SHL; w_wbEn = 1'b1; w_twoSrc = 1'b1; end
      OP_SRA:  begin w_exeCmd = EXE_SRA; w_wbEn = 1'b1; w_twoSrc = 1'b1; end
      OP_SRL:  begin w_exeCmd = EXE_SRL; w_wbEn = 1'b1; w_twoSrc = 1'b1; end
      OP_ADDI: begin w_exeCmd = EXE_ADD; w_wbEn = 1'b1; w_isImm = 1'b1; end
      OP_SUBI: begin w_exeCmd = EXE_SUB; w_wbEn = 1'b1; w_isImm = 1'b1; end
      OP_LD: begin
        w_exeCmd = EXE_ADD;
        w_isImm  = 1'b1;
        w_memR   = 1'b1;
        w_wbEn   = 1'b1;
      end
      OP_ST: begin
        w_exeCmd  = EXE_ADD;
        w_isImm   = 1'b1;
        w_memW    = 1'b1;
        w_isStore = 1'b1;
        w_twoSrc  = 1'b1;
      end
      OP_BEZ:  w_brType = BR_BEZ;
      OP_BNE:  begin w_brType = BR_BNE; w_twoSrc = 1'b1; end
      OP_JMP:  w_brType = BR_JMP;
      default: ;
    endcase
  end

  // A store reads its data register through the second port, so src2 is
  // redirected to the dest field; this makes st_val carry R[dest] for ST.
  // For other instructions st_val is the second read operand and unused.
  assign src1    = instr_in[SRC1_HI:SRC1_LO];
  assign src2    = w_isStore ? w_destIdx : w_src2Field;
  assign two_src = w_twoSrc;

  id_stage_reg_file #(
    .REG_COUNT (REG_COUNT),
    .DATA_W    (DATA_W),
    .ADDR_W    (5)
  ) u_regFile (
    .clk      (clk),
    .rst      (rst),
    .i_we     (wb_en),
    .i_waddr  (wb_dest),
    .i_wdata  (wb_val),
    .i_raddr1 (src1),
    .i_raddr2 (src2),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2)
  );

  // ID/EX pipeline register: reset, then flush (bubble with zeroed data),
  // then freeze (hold), otherwise capture the freshly decoded instruction.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_pc     <= '0;
      r_val1   <= '0;
      r_val2   <= '0;
      r_stVal  <= '0;
      r_dest   <= '0;
      r_exeCmd <= EXE_NONE;
      r_memR   <= 1'b0;
      r_memW   <= 1'b0;
      r_wbEn   <= 1'b0;
      r_brType <= BR_NONE;
      r_brAddr <= '0;
    end else if (!freeze) begin
      r_pc     <= pc_in;
      r_val1   <= w_rdata1;
      r_val2   <= w_isImm ? w_immExt : w_rdata2;
      r_stVal  <= w_rdata2;
      r_dest   <= w_destIdx;
      r_exeCmd <= w_exeCmd;
      r_memR   <= w_memR;
      r_memW   <= w_memW;
      r_wbEn   <= w_wbEn;
      r_brType <= w_brType;
      r_brAddr <= w_brAddr;
    end
  end

  assign pc_out    = r_pc;
  assign val1      = r_val1;
  assign val2      = r_val2;
  assign st_val    = r_stVal;
  assign dest      = r_dest;
  assign exe_cmd   = r_exeCmd;
  assign mem_r_en  = r_memR;
  assign mem_w_en  = r_memW;
  assign wb_en_out = r_wbEn;
  assign br_type   = r_brType;
  assign br_addr   = r_brAddr;

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage
// Directed scoreboard bench for id_stage. Each step drives one cycle of
// inputs, predicts the ID/EX contents from a behavioural model of the
// decoder and register file, queues the prediction, and pops it one cycle
// later to compare against the registered outputs.
// ---------------------------------------------------------------------------
module tb_id_stage;

  typedef struct packed {
    logic [3:0] cmd;
    logic       mr;
    logic       mw;
    logic       wb;
    logic [1:0] br;
    logic       isImm;
    logic       twoSrc;
    logic       isSt;
  } dec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] stv;
    logic [31:0] brAddr;
    logic [4:0]  dest;
    logic [3:0]  cmd;
    logic        mr;
    logic        mw;
    logic        wb;
    logic [1:0]  br;
    logic        chkSt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        flush;
  logic [31:0] pcIn;
  logic [31:0] instrIn;
  logic        wbEn;
  logic [4:0]  wbDest;
  logic [31:0] wbVal;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic        twoSrc;
  logic [31:0] pcOut;
  logic [31:0] val1;
  logic [31:0] val2;
  logic [31:0] stVal;
  logic [4:0]  dest;
  logic [3:0]  exeCmd;
  logic        memREn;
  logic        memWEn;
  logic        wbEnOut;
  logic [1:0]  brType;
  logic [31:0] brAddr;

  int          errors = 0;
  int          checks = 0;
  exp_t        expQ[$];
  exp_t        mHeld;
  logic [31:0] mRegs [32];

  id_stage dut (
    .clk       (clk),
    .rst       (rst),
    .freeze    (freeze),
    .flush     (flush),
    .pc_in     (pcIn),
    .instr_in  (instrIn),
    .wb_en     (wbEn),
    .wb_dest   (wbDest),
    .wb_val    (wbVal),
    .src1      (src1),
    .src2      (src2),
    .two_src   (twoSrc),
    .pc_out    (pcOut),
    .val1      (val1),
    .val2      (val2),
    .st_val    (stVal),
    .dest      (dest),
    .exe_cmd   (exeCmd),
    .mem_r_en  (memREn),
    .mem_w_en  (memWEn),
    .wb_en_out (wbEnOut),
    .br_type   (brType),
    .br_addr   (brAddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rInstr(input logic [5:0] op, input logic [4:0] d,
                                         input logic [4:0] s1, input logic [4:0] s2);
    return {op, d, s1, s2, 11'b0};
  endfunction

  function automatic logic [31:0] iInstr(input logic [5:0] op, input logic [4:0] d,
                                         input logic [4:0] s1, input logic [15:0] imm);
    return {op, d, s1, imm};
  endfunction

  // Reference decode table, written straight from the opcode list
  function automatic dec_t modelDecode(input logic [5:0] op);
    dec_t d;
    d = '0;
    case (op)
      6'd1:  begin d.cmd = 4'd1; d.wb = 1'b1; d.twoSrc = 1'b1; end
      6'd3:  begin d.cmd = 4'd2; d.wb = 1'b1; d.twoSrc = 1'b1; end
      6'd5:  begin d.cmd = 4'd3; d.wb = 1'b1; d.twoSrc = 1'b1; end
      6'd6:  begin d.cmd = 4'd4; d.wb = 1'b1; d.twoSrc = 1'b1; end
      6'd7:  begin d.cmd = 4'd5; d.wb = 1'b1; d.twoSrc = 1'b1; end
      6'd8:  begin d.cmd = 4'd6; d.wb = 1'b1; d.twoSrc = 1'b1; end
      6'd9:  begin d.cmd = 4'd7; d.wb = 1'b1; d.twoSrc = 1'b1; end
      6'd10: begin d.cmd = 4'd7; d.wb = 1'b1; d.twoSrc = 1'b1; end
      6'd11: begin d.cmd = 4'd8; d.wb = 1'b1; d.twoSrc = 1'b1; end
      6'd12: begin d.cmd = 4'd9; d.wb = 1'b1; d.twoSrc = 1'b1; end
      6'd32: begin d.cmd = 4'd1; d.wb = 1'b1; d.isImm = 1'b1; end
      6'd33: begin d.cmd = 4'd2; d.wb = 1'b1; d.isImm = 1'b1; end
      6'd36: begin d.cmd = 4'd1; d.wb = 1'b1; d.isImm = 1'b1; d.mr = 1'b1; end
      6'd37: begin d.cmd = 4'd1; d.isImm = 1'b1; d.mw = 1'b1; d.twoSrc = 1'b1; d.isSt = 1'b1; end
      6'd40: d.br = 2'd1;
      6'd41: begin d.br = 2'd2; d.twoSrc = 1'b1; end
      6'd42: d.br = 2'd3;
      default: ;
    endcase
    return d;
  endfunction

  // Register read as seen during a cycle with a pending write-back
  function automatic logic [31:0] readModel(input logic [4:0] idx, input logic we,
                                            input logic [4:0] wd, input logic [31:0] wv);
    if (idx == 5'd0) return 32'd0;
    if (we && (wd == idx)) return wv;
    return mRegs[idx];
  endfunction

  task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drives one cycle of inputs, queues the predicted ID/EX contents and
  // checks the combinational hazard-unit outputs.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] instr,
                               input logic fz, input logic fl, input logic we,
                               input logic [4:0] wd, input logic [31:0] wv);
    dec_t        d;
    exp_t        e;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [31:0] immExt;
    rst     = 1'b0;
    pcIn    = pc;
    instrIn = instr;
    freeze  = fz;
    flush   = fl;
    wbEn    = we;
    wbDest  = wd;
    wbVal   = wv;
    d       = modelDecode(instr[31:26]);
    s1      = instr[20:16];
    s2      = d.isSt ? instr[25:21] : instr[15:11];
    immExt  = {{16{instr[15]}}, instr[15:0]};
    if (fl) begin
      e       = '0;
      e.chkSt = 1'b1;
    end else if (fz) begin
      e = mHeld;
    end else begin
      e.pc     = pc;
      e.v1     = readModel(s1, we, wd, wv);
      e.v2     = d.isImm ? immExt : readModel(s2, we, wd, wv);
      e.stv    = readModel(instr[25:21], we, wd, wv);
      e.chkSt  = d.isSt;
      e.brAddr = pc + (immExt << 2);
      e.dest   = instr[25:21];
      e.cmd    = d.cmd;
      e.mr     = d.mr;
      e.mw     = d.mw;
      e.wb     = d.wb;
      e.br     = d.br;
    end
    expQ.push_back(e);
    mHeld = e;
    if (we && (wd != 5'd0)) mRegs[wd] = wv;
    #1;
    checkField("src1", {27'd0, src1}, {27'd0, s1});
    checkField("src2", {27'd0, src2}, {27'd0, s2});
    checkField("two_src", {31'd0, twoSrc}, {31'd0, d.twoSrc});
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = expQ.pop_front();
      checkField("pc_out", pcOut, e.pc);
      checkField("val1", val1, e.v1);
      checkField("val2", val2, e.v2);
      if (e.chkSt) checkField("st_val", stVal, e.stv);
      checkField("dest", {27'd0, dest}, {27'd0, e.dest});
      checkField("exe_cmd", {28'd0, exeCmd}, {28'd0, e.cmd});
      checkField("mem_r_en", {31'd0, memREn}, {31'd0, e.mr});
      checkField("mem_w_en", {31'd0, memWEn}, {31'd0, e.mw});
      checkField("wb_en_out", {31'd0, wbEnOut}, {31'd0, e.wb});
      checkField("br_type", {30'd0, brType}, {30'd0, e.br});
      checkField("br_addr", brAddr, e.brAddr);
    end
  endtask

  task automatic step(input logic [31:0] pc, input logic [31:0] instr,
                      input logic fz, input logic fl, input logic we,
                      input logic [4:0] wd, input logic [31:0] wv);
    applyStimulus(pc, instr, fz, fl, we, wd, wv);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic resetCycles(input int n);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      rst     = 1'b1;
      freeze  = 1'b0;
      flush   = 1'b0;
      pcIn    = 32'd0;
      instrIn = 32'd0;
      wbEn    = 1'b0;
      wbDest  = 5'd0;
      wbVal   = 32'd0;
      e       = '0;
      e.chkSt = 1'b1;
      expQ.push_back(e);
      mHeld = e;
      for (int r = 0; r < 32; r++) mRegs[r] = 32'd0;
      @(posedge clk);
      #1;
      checkOutput();
    end
  endtask

  // Directed sequence
  initial begin
    logic [5:0] aluOps [9];
    aluOps = '{6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12};

    resetCycles(2);
    step(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    // Every register reads zero after reset
    for (int i = 1; i < 32; i += 2) begin
      step(32'd4, rInstr(6'd1, 5'd0, 5'(i), 5'(i + 1)), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    end

    step(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd5);
    step(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd2, 32'd7);
    step(32'd8, 32'h04611000, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step(32'hC, iInstr(6'd32, 5'd4, 5'd1, 16'hFFFC), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step(32'h20, iInstr(6'd41, 5'd1, 5'd2, 16'd3), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

    // Same-cycle write-back bypass, and R0 writes ignored
    step(32'h24, rInstr(6'd1, 5'd5, 5'd1, 5'd2), 1'b0, 1'b0, 1'b1, 5'd1, 32'd9);
    step(32'h28, rInstr(6'd1, 5'd6, 5'd0, 5'd2), 1'b0, 1'b0, 1'b1, 5'd0, 32'h55);
    step(32'h2C, rInstr(6'd1, 5'd7, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

    // Memory ops: store data comes from the dest register
    step(32'h30, iInstr(6'd37, 5'd2, 5'd1, 16'd8), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step(32'h34, iInstr(6'd36, 5'd8, 5'd1, 16'h8000), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

    // Remaining ALU ops, immediates, branches and unknown opcodes
    step(32'h38, 32'd0, 1'b0, 1'b0, 1'b1, 5'd31, 32'hDEADBEEF);
    foreach (aluOps[k]) begin
      step(32'h40 + 32'(k * 4), rInstr(aluOps[k], 5'(k + 10), 5'd31, 5'd2),
           1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    end
    step(32'h80, iInstr(6'd33, 5'd9, 5'd31, 16'h7FFF), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step(32'h84, iInstr(6'd40, 5'd0, 5'd1, 16'hFFFE), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step(32'h88, iInstr(6'd42, 5'd0, 5'd0, 16'h0100), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step(32'h8C, rInstr(6'd63, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step(32'h90, rInstr(6'd2, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

    // Freeze holds outputs while the write port keeps working
    step(32'h94, rInstr(6'd8, 5'd12, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step(32'h98, rInstr(6'd3, 5'd13, 5'd2, 5'd1), 1'b1, 1'b0, 1'b1, 5'd10, 32'h1234);
    step(32'h9C, iInstr(6'd36, 5'd14, 5'd2, 16'd4), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    step(32'hA0, rInstr(6'd1, 5'd15, 5'd10, 5'd1), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

    // Flush beats freeze; flush alone
    step(32'hA4, iInstr(6'd37, 5'd10, 5'd1, 16'd2), 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    step(32'hA8, iInstr(6'd36, 5'd11, 5'd1, 16'd2), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step(32'hAC, rInstr(6'd1, 5'd11, 5'd1, 5'd2), 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);

    // Reset mid-operation clears both the pipeline register and the file
    step(32'hB0, rInstr(6'd1, 5'd3, 5'd1, 5'd10), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    resetCycles(1);
    step(32'hB4, rInstr(6'd1, 5'd3, 5'd1, 5'd10), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

    checks++;
    assert (expQ.size() == 0) else begin
      errors++;
      $error("[TB] FAIL queue_drain observed=%0d expected=0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
